// File: rtl/mem_fifo_arb_if.sv
// rtl/mem_fifo_arb_if.sv - requester, memory and status signals of the FIFO arbiter
interface mem_fifo_arb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              wr_req;
  logic [DATA_W-1:0] wdata;
  logic              wr_gnt;
  logic              rd_req;
  logic              rd_gnt;
  logic [DATA_W-1:0] rdata;
  logic              rd_valid;
  logic              flush;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow_err;
  logic              underflow_err;

  modport slave (
    input  wr_req, wdata, rd_req, flush, mem_rdata,
    output wr_gnt, rd_gnt, rdata, rd_valid, mem_en, mem_we, mem_addr, mem_wdata,
           waddr, raddr, count, full, empty, overflow_err, underflow_err
  );

  modport master (
    output wr_req, wdata, rd_req, flush, mem_rdata,
    input  wr_gnt, rd_gnt, rdata, rd_valid, mem_en, mem_we, mem_addr, mem_wdata,
           waddr, raddr, count, full, empty, overflow_err, underflow_err
  );
endinterface

// File: rtl/mem_fifo_arb.sv
// rtl/mem_fifo_arb.sv - FIFO over a single-port buffer memory with write/read arbitration
// One memory access per cycle; conflicting requests alternate, loser of the last conflict wins next.
module mem_fifo_arb #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic          clk_rcv25,
  input  logic          reset,
  mem_fifo_arb_if.slave bus
);
  localparam logic              LW_READ  = 1'b0;
  localparam logic              LW_WRITE = 1'b1;
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W:0]   count;
  logic              rd_valid;
  logic              last_win;
  logic              overflow_err;
  logic              underflow_err;
  logic              full;
  logic              empty;
  logic              wr_elig;
  logic              rd_elig;
  logic              wr_gnt;
  logic              rd_gnt;
  logic [DATA_W-1:0] wdata;

  // full/empty are forced to their idle values while reset is asserted
  assign full    = !reset && (count == CNT_FULL);
  assign empty   = reset || (count == '0);
  assign wr_elig = !reset && bus.wr_req && !full && !bus.flush;
  assign rd_elig = !reset && bus.rd_req && !empty && !bus.flush;
  assign wr_gnt  = wr_elig && (!rd_elig || last_win == LW_READ);
  assign rd_gnt  = rd_elig && (!wr_elig || last_win == LW_WRITE);
  assign wdata   = bus.wdata;

  assign bus.wr_gnt        = wr_gnt;
  assign bus.rd_gnt        = rd_gnt;
  assign bus.mem_en        = wr_gnt || rd_gnt;
  assign bus.mem_we        = wr_gnt;
  assign bus.mem_addr      = wr_gnt ? waddr : raddr;
  assign bus.mem_wdata     = wdata;
  assign bus.rdata         = bus.mem_rdata;
  assign bus.rd_valid      = rd_valid;
  assign bus.waddr         = waddr;
  assign bus.raddr         = raddr;
  assign bus.count         = count;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.overflow_err  = overflow_err;
  assign bus.underflow_err = underflow_err;

  always_ff @(posedge clk_rcv25) begin
    if (reset) begin
      waddr         <= '0;
      raddr         <= '0;
      count         <= '0;
      rd_valid      <= 1'b0;
      last_win      <= LW_READ;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      rd_valid <= rd_gnt;
      if (bus.flush) begin
        waddr <= '0;
        raddr <= '0;
        count <= '0;
      end else if (wr_gnt) begin
        waddr <= waddr + PTR_ONE;
        count <= count + CNT_ONE;
      end else if (rd_gnt) begin
        raddr <= raddr + PTR_ONE;
        count <= count - CNT_ONE;
      end
      // only a genuine conflict moves the fairness pointer
      if (wr_elig && rd_elig)
        last_win <= wr_gnt ? LW_WRITE : LW_READ;
      if (bus.wr_req && full)
        overflow_err <= 1'b1;
      if (bus.rd_req && empty)
        underflow_err <= 1'b1;
    end
  end
endmodule
